// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks a 3-input gate through all eight input rows,
// double-samples its output per row and compares the assembled code to an expected one.
module truth_table_sweeper #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       gate_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [7:0] truth_table,
    output logic       match,
    output logic       unstable
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_SAMP1 = 3'd2;
    localparam logic [2:0] S_SAMP2 = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    logic [2:0]       state, state_n;
    logic [2:0]       row, row_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             s1, s1_n;
    logic [7:0]       exp_q, exp_n;
    logic [7:0]       tt_n;
    logic             match_n, unstable_n, done_n, aborted_n, busy_n;
    logic [2:0]       ins_n;

    // Every architectural value is computed here and registered below, so all outputs are flops.
    always_comb begin
        state_n    = state;
        row_n      = row;
        cnt_n      = cnt;
        s1_n       = s1;
        exp_n      = exp_q;
        tt_n       = truth_table;
        match_n    = match;
        unstable_n = unstable;
        done_n     = 1'b0;
        aborted_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    exp_n      = expected;
                    tt_n       = 8'h00;
                    match_n    = 1'b0;
                    unstable_n = 1'b0;
                    row_n      = 3'd0;
                    cnt_n      = '0;
                    state_n    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == SETTLE_LAST) begin
                    state_n = S_SAMP1;
                end
            end
            S_SAMP1: begin
                s1_n    = gate_out;
                state_n = S_SAMP2;
            end
            S_SAMP2: begin
                tt_n[3'd7 - row] = gate_out;
                if (gate_out != s1) begin
                    unstable_n = 1'b1;
                end
                if (row == 3'd7) begin
                    // Compare against the code including the row-7 bit written this cycle.
                    match_n = (tt_n == exp_q);
                    done_n  = 1'b1;
                    state_n = S_FIN;
                end else begin
                    row_n   = row + 3'd1;
                    cnt_n   = '0;
                    state_n = S_DRIVE;
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort overrides whatever the sweep states decided this cycle.
        if (abort && (state == S_DRIVE || state == S_SAMP1 || state == S_SAMP2)) begin
            state_n   = S_IDLE;
            row_n     = 3'd0;
            cnt_n     = '0;
            match_n   = 1'b0;
            done_n    = 1'b0;
            aborted_n = 1'b1;
        end

        busy_n = (state_n != S_IDLE);
        ins_n  = (state_n == S_DRIVE || state_n == S_SAMP1 || state_n == S_SAMP2) ? row_n : 3'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            row         <= 3'd0;
            cnt         <= '0;
            s1          <= 1'b0;
            exp_q       <= 8'h00;
            truth_table <= 8'h00;
            match       <= 1'b0;
            unstable    <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            busy        <= 1'b0;
            in1         <= 1'b0;
            in2         <= 1'b0;
            in3         <= 1'b0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            cnt         <= cnt_n;
            s1          <= s1_n;
            exp_q       <= exp_n;
            truth_table <= tt_n;
            match       <= match_n;
            unstable    <= unstable_n;
            done        <= done_n;
            aborted     <= aborted_n;
            busy        <= busy_n;
            in1         <= ins_n[2];
            in2         <= ins_n[1];
            in3         <= ins_n[0];
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a behavioural 3-input gate model.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       gate_out;
    logic       in1, in2, in3;
    logic       busy, done, aborted;
    logic [7:0] truth_table;
    logic       match, unstable;

    logic [7:0] gate_code;
    logic       flip;
    logic [2:0] row_now;

    int vectors = 0;
    int miscompares = 0;

    truth_table_sweeper #(.SETTLE(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .expected(expected), .gate_out(gate_out),
        .in1(in1), .in2(in2), .in3(in3),
        .busy(busy), .done(done), .aborted(aborted),
        .truth_table(truth_table), .match(match), .unstable(unstable)
    );

    always #5 clk = ~clk;

    // Gate under test: bit (7-r) of gate_code is f(row r); flip injects a glitch.
    assign row_now  = {in1, in2, in3};
    assign gate_out = gate_code[3'd7 - row_now] ^ flip;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a sweep; cycle n is the interval after edge n-1 (start edge is edge 0).
    task automatic run_sweep(input logic [7:0] code, input logic [7:0] exp_code,
                             input int flip_cycle, input bit spam,
                             output int done_cyc, output int n_done,
                             output logic [7:0] tt_done, output logic match_done,
                             output logic unst_done);
        gate_code = code;
        expected  = exp_code;
        done_cyc  = 0;
        n_done    = 0;
        tt_done   = 8'h00;
        match_done = 1'b0;
        unst_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc   = cyc;
                    tt_done    = truth_table;
                    match_done = match;
                    unst_done  = unstable;
                end
            end
            flip  = (cyc == flip_cycle);
            start = spam && (cyc >= 2) && (cyc <= 30);
            tick();
        end
        flip  = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        vectors++;
        if ({busy, done, aborted, in1, in2, in3, truth_table, match, unstable} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %b required 0", {busy, done, aborted, in1, in2, in3, truth_table, match, unstable});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_match();
        int dc, nd;
        logic [7:0] tt;
        logic m, u;
        run_sweep(8'h03, 8'h03, 0, 1'b0, dc, nd, tt, m, u);
        vectors++;
        if (tt !== 8'h03) begin miscompares++; $display("FAIL match_tt: got %h required 03", tt); end
        vectors++;
        if (m !== 1'b1) begin miscompares++; $display("FAIL match_flag: got %b required 1", m); end
        vectors++;
        if (u !== 1'b0) begin miscompares++; $display("FAIL match_unstable: got %b required 0", u); end
        vectors++;
        if (dc !== 33) begin miscompares++; $display("FAIL match_done_cycle: got %0d required 33", dc); end
        vectors++;
        if (nd !== 1) begin miscompares++; $display("FAIL match_done_count: got %0d required 1", nd); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL match_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_mismatch();
        int dc, nd;
        logic [7:0] tt;
        logic m, u;
        run_sweep(8'h03, 8'hC0, 0, 1'b0, dc, nd, tt, m, u);
        vectors++;
        if (tt !== 8'h03) begin miscompares++; $display("FAIL mismatch_tt: got %h required 03", tt); end
        vectors++;
        if (m !== 1'b0) begin miscompares++; $display("FAIL mismatch_flag: got %b required 0", m); end
        vectors++;
        if (nd !== 1) begin miscompares++; $display("FAIL mismatch_done_count: got %0d required 1", nd); end
    endtask

    // Row 3 SAMP2 occupies cycle 16; glitch the gate only then.
    task automatic test_unstable();
        int dc, nd;
        logic [7:0] tt;
        logic m, u;
        run_sweep(8'h03, 8'h03, 16, 1'b0, dc, nd, tt, m, u);
        vectors++;
        if (u !== 1'b1) begin miscompares++; $display("FAIL unstable_flag: got %b required 1", u); end
        vectors++;
        if (tt !== 8'h13) begin miscompares++; $display("FAIL unstable_tt: got %h required 13", tt); end
        vectors++;
        if (m !== 1'b0) begin miscompares++; $display("FAIL unstable_match: got %b required 0", m); end
    endtask

    task automatic test_abort();
        int nd;
        nd = 0;
        gate_code = 8'hA5;
        expected  = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 17; cyc++) begin
            if (done === 1'b1) nd++;
            tick();
        end
        vectors++;
        if ({in1, in2, in3} !== 3'b100) begin miscompares++; $display("FAIL abort_row4_inputs: got %b required 100", {in1, in2, in3}); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (aborted !== 1'b1) begin miscompares++; $display("FAIL abort_pulse: got %b required 1", aborted); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b required 0", busy); end
        vectors++;
        if ({in1, in2, in3} !== 3'b000) begin miscompares++; $display("FAIL abort_inputs: got %b required 000", {in1, in2, in3}); end
        vectors++;
        if (truth_table !== 8'hA0) begin miscompares++; $display("FAIL abort_tt: got %h required a0", truth_table); end
        vectors++;
        if (match !== 1'b0) begin miscompares++; $display("FAIL abort_match: got %b required 0", match); end
        tick();
        vectors++;
        if (aborted !== 1'b0) begin miscompares++; $display("FAIL abort_pulse_width: got %b required 0", aborted); end
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (done === 1'b1) nd++;
            tick();
        end
        vectors++;
        if (nd !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d required 0", nd); end
    endtask

    task automatic test_start_spam();
        int dc, nd;
        logic [7:0] tt;
        logic m, u;
        run_sweep(8'h5A, 8'h5A, 0, 1'b1, dc, nd, tt, m, u);
        vectors++;
        if (dc !== 33) begin miscompares++; $display("FAIL spam_done_cycle: got %0d required 33", dc); end
        vectors++;
        if (nd !== 1) begin miscompares++; $display("FAIL spam_done_count: got %0d required 1", nd); end
        vectors++;
        if (tt !== 8'h5A || m !== 1'b1) begin miscompares++; $display("FAIL spam_result: got tt=%h match=%b required 5a/1", tt, m); end
    endtask

    task automatic test_reset_mid_sweep();
        int dc, nd;
        logic [7:0] tt;
        logic m, u;
        gate_code = 8'hFF;
        expected  = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 21; cyc++) tick();
        vectors++;
        if ({in1, in2, in3} !== 3'b101) begin miscompares++; $display("FAIL rst_row5_inputs: got %b required 101", {in1, in2, in3}); end
        vectors++;
        if (truth_table !== 8'hF8) begin miscompares++; $display("FAIL rst_partial_tt: got %h required f8", truth_table); end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, aborted, in1, in2, in3, truth_table, match, unstable} !== 15'd0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got %b required 0", {busy, done, aborted, in1, in2, in3, truth_table, match, unstable});
        end
        #3;
        reset = 1'b0;
        tick();
        run_sweep(8'h96, 8'h96, 0, 1'b0, dc, nd, tt, m, u);
        vectors++;
        if (tt !== 8'h96 || m !== 1'b1 || dc !== 33) begin
            miscompares++;
            $display("FAIL rst_fresh_sweep: got tt=%h match=%b cyc=%0d required 96/1/33", tt, m, dc);
        end
    endtask

    task automatic test_exhaustive();
        int dc, nd;
        logic [7:0] tt;
        logic m, u;
        logic [7:0] code;
        for (int f = 0; f < 256; f++) begin
            code = 8'(f);
            run_sweep(code, code, 0, 1'b0, dc, nd, tt, m, u);
            vectors++;
            if (tt !== code || m !== 1'b1 || nd !== 1) begin
                miscompares++;
                $display("FAIL exhaustive_%02h: got tt=%h match=%b done=%0d required %h/1/1", code, tt, m, nd, code);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        expected = 8'h00;
        gate_code = 8'h00;
        flip = 1'b0;
        test_reset();
        test_match();
        test_mismatch();
        test_unstable();
        test_abort();
        test_start_spam();
        test_reset_mid_sweep();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exhaustively exercises one 3-input logic gate from the 3-input-case library (any of the 256 `0xNN` functions) and records its truth table. It drives the gate's three inputs through all eight combinations. After a programmable settle time it samples the gate output twice, assembles an 8-bit truth-table code and compares it against an expected code. It sits between the characterisation/self-test controller and the gate under test.

## Interface
Parameters:
- SETTLE, 2: cycles inputs are held before first sample; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- abort  input  1  cancel a sweep in progress.
- expected  input  8  expected truth-table code; captured when start is accepted.
- gate_out  input  1  output of the gate under test.
- in1, in2, in3  output  1 each  inputs driven to the gate under test; {in1,in2,in3} = current row.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a full sweep completes.
- aborted  output  1  one-cycle pulse when a sweep is cancelled.
- truth_table  output  8  assembled code; bit (7-r) = gate_out for row r (row 000 = MSB).
- match  output  1  truth_table == captured expected; valid from done onward.
- unstable  output  1  sticky per sweep: some row's two samples differed.

## Operation
- States: IDLE, DRIVE, SAMP1, SAMP2, FIN.
- IDLE:
  - {in1,in2,in3} = 000; busy = 0.
  - start=1 → capture expected; clear truth_table, match and unstable; row = 0; settle counter = 0; go to DRIVE.
- DRIVE:
  - {in1,in2,in3} = row.
  - Counter increments each cycle.
  - When counter == SETTLE-1 → SAMP1. DRIVE therefore lasts exactly SETTLE cycles.
- SAMP1: latch gate_out into s1 → SAMP2.
- SAMP2:
  - Write gate_out into truth_table bit (7-row).
  - If gate_out != s1, set unstable.
  - If row == 7 → FIN. Otherwise row+1, counter = 0 → DRIVE.
  - Row never wraps within a sweep.
- FIN:
  - done = 1 for one cycle.
  - match = (truth_table == expected), with truth_table including the row-7 bit written in SAMP2.
  - Then → IDLE.
- Inputs hold the current row through DRIVE, SAMP1 and SAMP2.
- Abort:
  - abort=1 in DRIVE, SAMP1 or SAMP2 → IDLE next cycle.
  - aborted pulses for that one cycle; done is not pulsed.
  - truth_table retains partially written bits; match is forced 0.
  - abort takes priority over any transition in the same cycle.
  - abort in IDLE or FIN is ignored.
- start while busy is ignored; it is not queued.
- start and abort high together in IDLE: start wins.
- Reset, at any time including mid-sweep, forces IDLE on the next edge-independent assertion:
  - in1..in3 = 0, busy = 0, done = 0, aborted = 0.
  - truth_table = 0x00, match = 0, unstable = 0.
  - row = 0, counter = 0, captured expected = 0x00.
- All outputs are registered.

## Timing
- Per row: SETTLE (DRIVE) + 1 (SAMP1) + 1 (SAMP2) cycles.
- Start sampled high at edge 0 → busy high after edge 0. done is high in cycle 8·(SETTLE+2)+1, i.e. 33 with SETTLE=2, then busy falls.
- Back-to-back sweeps: start may be accepted in the first IDLE cycle after FIN, giving a minimum gap of 1 cycle.
- gate_out is assumed synchronous to clk. Its combinational path from in1..in3 must settle within SETTLE cycles.

## Test plan
- Gate model f = 1 for rows 110 and 111, expected = 0x03, SETTLE = 2: truth_table = 0x03, match = 1, unstable = 0, done pulses exactly in cycle 33.
- Same gate, expected = 0xC0: truth_table = 0x03, match = 0, done still pulses once.
- Gate output toggled between SAMP1 and SAMP2 on row 011 only: unstable = 1; bit 4 equals the SAMP2 value.
- abort asserted in DRIVE of row 4: aborted pulses once, no done, busy falls next cycle, in1..in3 = 000, bits 7..4 retain rows 0–3, match = 0.
- start re-asserted repeatedly during a sweep: sweep completes normally with one done and unchanged timing. Then reset asserted mid-sweep at row 5: all outputs zero immediately, and a fresh start produces the correct code.
- Exhaustive: all 256 gate functions with expected = function code: truth_table equals the code and match = 1 for each.
